// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128 cipher core with one shared round datapath.
//
// The round datapath is reused over several clocks. It evaluates ROUNDS_PER_CYCLE
// rounds per clock. Plaintext and Cipherkey are captured when Run is accepted in
// IDLE. The result stays in Ciphertext until the next operation completes.
// Key expansion and byte substitution are local functions, so this file needs
// no other source. KEY_LAT models the settling time of the key schedule: the
// core waits that many clocks after capturing the key.
//
// Parameters:
//   DECRYPT          0 = encrypt, 1 = inverse cipher (InvShiftRows/InvSubBytes/
//                    AddRoundKey/InvMixColumns)
//   ROUNDS_PER_CYCLE rounds evaluated per clock: 1, 2 or 5
//   KEY_LAT          clocks to wait for the key schedule: 0..4
//
// Ports:
//   Clk        in   clock, rising edge
//   Reset      in   synchronous, active-high reset
//   Run        in   start request, level-sampled in IDLE
//   Plaintext  in   128-bit input block (ciphertext when decrypting), bit 127 = byte 0 MSB
//   Cipherkey  in   128-bit key, same byte order
//   Ciphertext out  registered result, updated only on entry to DONE
//   Ready      out  high in DONE
//   Busy       out  high in KEYWAIT, INIT and ROUND
module aes_iter_core #(
  parameter bit          DECRYPT          = 1'b0,
  parameter int unsigned ROUNDS_PER_CYCLE = 1,
  parameter int unsigned KEY_LAT          = 1
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Run,
  input  logic [127:0] Plaintext,
  input  logic [127:0] Cipherkey,
  output logic [127:0] Ciphertext,
  output logic         Ready,
  output logic         Busy
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 5))
  begin : gen_bad_rpc
    $error("aes_iter_core: ROUNDS_PER_CYCLE must be 1, 2 or 5");
  end
  if (KEY_LAT > 4) begin : gen_bad_key_lat
    $error("aes_iter_core: KEY_LAT must be in 0..4");
  end

  // Round key i sits at index i, which is the MSB end of the 1408-bit schedule.
  typedef logic [0:10][127:0] ksched_t;

  typedef enum logic [2:0] {StIdle, StKeyWait, StInit, StRound, StDone} state_e;

  localparam logic [2:0] KwLast  = (KEY_LAT == 0) ? 3'd0 : 3'(KEY_LAT - 1);
  localparam logic [3:0] InitKey = DECRYPT ? 4'd10 : 4'd0;
  localparam logic [3:0] RpcStep = 4'(ROUNDS_PER_CYCLE);

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic and S-boxes
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      acc = gmul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] v;
    v = gf_inv(x);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]}
           ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] v;
    v = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(v);
  endfunction

  // ---------------------------------------------------------------------------
  // Round transformations. Byte n of a block is bits [127-8n -: 8]; the state
  // is column-major, so byte n is row n%4 of column n/4.
  // ---------------------------------------------------------------------------
  function automatic logic [127:0] sub_bytes(input logic [127:0] st);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[127 - 8*n -: 8] = sbox(st[127 - 8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] st);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[127 - 8*n -: 8] = inv_sbox(st[127 - 8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] st);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = st[127 - 8*(4*((c + r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] st);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = st[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] st);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127 - 32*c -: 32] = mix_col(st[127 - 32*c -: 32]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] st);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) o[127 - 32*c -: 32] = inv_mix_col(st[127 - 32*c -: 32]);
    return o;
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    t = shift_rows(sub_bytes(st));
    if (!last) t = mix_columns(t);
    return t ^ rk;
  endfunction

  function automatic logic [127:0] dec_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic last);
    logic [127:0] t;
    t = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
    if (!last) t = inv_mix_columns(t);
    return t;
  endfunction

  // ---------------------------------------------------------------------------
  // Key expansion: 44 words, packed four per round key.
  // ---------------------------------------------------------------------------
  function automatic ksched_t expand_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] temp;
    logic [7:0]  rcon;
    ksched_t     ks;
    w[0] = key[127:96];
    w[1] = key[95:64];
    w[2] = key[63:32];
    w[3] = key[31:0];
    rcon = 8'h01;
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = {temp[23:0], temp[31:24]};
        temp = {sbox(temp[31:24]), sbox(temp[23:16]), sbox(temp[15:8]), sbox(temp[7:0])};
        temp[31:24] = temp[31:24] ^ rcon;
        rcon = xtime(rcon);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int k = 0; k < 11; k++) ks[k] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
    return ks;
  endfunction

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  state_e       state;
  logic [3:0]   round_cnt;
  logic [2:0]   kw_cnt;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  ksched_t      key_sched;
  logic [127:0] round_out;
  logic [3:0]   round_next;

  assign key_sched  = expand_key(key_reg);
  assign round_next = round_cnt + RpcStep;

  // Chain of ROUNDS_PER_CYCLE rounds with indices round_cnt .. round_cnt+RPC-1.
  always_comb begin
    logic [127:0] chain;
    logic [3:0]   idx;
    chain = state_reg;
    idx   = round_cnt;
    for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
      idx = round_cnt + 4'(j);
      if (DECRYPT) chain = dec_round(chain, key_sched[4'd10 - idx], idx == 4'd10);
      else         chain = enc_round(chain, key_sched[idx], idx == 4'd10);
    end
    round_out = chain;
  end

  // ---------------------------------------------------------------------------
  // Control FSM; all outputs are registered here.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= StIdle;
      round_cnt  <= 4'd0;
      kw_cnt     <= 3'd0;
      state_reg  <= '0;
      key_reg    <= '0;
      Ciphertext <= '0;
      Ready      <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (Run) begin
            state_reg <= Plaintext;
            key_reg   <= Cipherkey;
            kw_cnt    <= 3'd0;
            Busy      <= 1'b1;
            state     <= (KEY_LAT == 0) ? StInit : StKeyWait;
          end
        end
        StKeyWait: begin
          if (kw_cnt == KwLast) state <= StInit;
          else                  kw_cnt <= kw_cnt + 3'd1;
        end
        StInit: begin
          state_reg <= state_reg ^ key_sched[InitKey];
          round_cnt <= 4'd1;
          state     <= StRound;
        end
        StRound: begin
          state_reg <= round_out;
          round_cnt <= round_next;
          if (round_next > 4'd10) begin
            Ciphertext <= round_out;
            Ready      <= 1'b1;
            Busy       <= 1'b0;
            state      <= StDone;
          end
        end
        StDone: begin
          // Holding Run high parks the core here; no automatic restart.
          if (!Run) begin
            Ready <= 1'b0;
            state <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_iter_core.sv
// Self-checking bench for aes_iter_core. Five instances share Clk/Reset/Run/Cipherkey:
// 0 = defaults, 1 = DECRYPT, 2 = RPC 2, 3 = RPC 5, 4 = KEY_LAT 0.
module tb_aes_iter_core;

  localparam logic [127:0] Key1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] Pt1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Ct1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Key2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Pt2  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] Ct2  = 128'h3925841d02dc09fbdc118597196a0b32;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         Run;
  logic [127:0] pt;
  logic [127:0] pt_dec;
  logic [127:0] key;
  logic [127:0] ct_o [5];
  logic [4:0]   rdy;
  logic [4:0]   bsy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int           inst;
    logic [127:0] data;
    int           lat;
  } exp_t;
  exp_t sb[$];

  int           lat_obs [5];
  logic [127:0] ct_obs  [5];
  int           busy_cnt;

  always #5 Clk = ~Clk;

  aes_iter_core u_enc (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Plaintext(pt), .Cipherkey(key),
    .Ciphertext(ct_o[0]), .Ready(rdy[0]), .Busy(bsy[0])
  );
  aes_iter_core #(.DECRYPT(1'b1)) u_dec (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Plaintext(pt_dec), .Cipherkey(key),
    .Ciphertext(ct_o[1]), .Ready(rdy[1]), .Busy(bsy[1])
  );
  aes_iter_core #(.ROUNDS_PER_CYCLE(2)) u_rpc2 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Plaintext(pt), .Cipherkey(key),
    .Ciphertext(ct_o[2]), .Ready(rdy[2]), .Busy(bsy[2])
  );
  aes_iter_core #(.ROUNDS_PER_CYCLE(5)) u_rpc5 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Plaintext(pt), .Cipherkey(key),
    .Ciphertext(ct_o[3]), .Ready(rdy[3]), .Busy(bsy[3])
  );
  aes_iter_core #(.KEY_LAT(0)) u_kl0 (
    .Clk(Clk), .Reset(Reset), .Run(Run), .Plaintext(pt), .Cipherkey(key),
    .Ciphertext(ct_o[4]), .Ready(rdy[4]), .Busy(bsy[4])
  );

  // One-clock Run pulse; returns on the falling edge just after E0 (k = 0).
  task automatic pulse_run;
    @(negedge Clk);
    Run = 1'b1;
    @(negedge Clk);
    Run = 1'b0;
  endtask

  // Records, per instance, the first k (falling edges after E0) with Ready high.
  task automatic measure(input int max_k);
    for (int i = 0; i < 5; i++) begin
      lat_obs[i] = -1;
      ct_obs[i]  = '0;
    end
    busy_cnt = 0;
    for (int k = 0; k <= max_k; k++) begin
      for (int i = 0; i < 5; i++) begin
        if (lat_obs[i] < 0 && rdy[i] === 1'b1) begin
          lat_obs[i] = k;
          ct_obs[i]  = ct_o[i];
        end
      end
      if (bsy[0] === 1'b1) busy_cnt++;
      @(negedge Clk);
    end
  endtask

  task automatic test_reset;
    Reset  = 1'b1;
    Run    = 1'b0;
    pt     = Pt1;
    pt_dec = Ct1;
    key    = Key1;
    repeat (3) @(negedge Clk);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (rdy[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_ready[%0d]: got %b want 0", i, rdy[i]);
      end
      total++;
      if (bsy[i] !== 1'b0) begin
        bad++;
        $display("FAIL reset_busy[%0d]: got %b want 0", i, bsy[i]);
      end
      total++;
      if (ct_o[i] !== 128'h0) begin
        bad++;
        $display("FAIL reset_ct[%0d]: got %h want 0", i, ct_o[i]);
      end
    end
    Reset = 1'b0;
    @(negedge Clk);
    total++;
    if (bsy !== 5'b0) begin
      bad++;
      $display("FAIL idle_after_reset_busy: got %b want 00000", bsy);
    end
  endtask

  // C.1 on every instance: encrypt/decrypt results and the latency sweep.
  task automatic test_latency_sweep;
    exp_t e;
    sb.push_back('{inst: 0, data: Ct1, lat: 12});
    sb.push_back('{inst: 1, data: Pt1, lat: 12});
    sb.push_back('{inst: 2, data: Ct1, lat: 7});
    sb.push_back('{inst: 3, data: Ct1, lat: 4});
    sb.push_back('{inst: 4, data: Ct1, lat: 11});
    pulse_run();
    measure(20);
    total++;
    if (busy_cnt !== 12) begin
      bad++;
      $display("FAIL sweep_busy_clocks: got %0d want 12", busy_cnt);
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      total++;
      if (lat_obs[e.inst] !== e.lat) begin
        bad++;
        $display("FAIL sweep_latency[%0d]: got %0d want %0d", e.inst, lat_obs[e.inst], e.lat);
      end
      total++;
      if (ct_obs[e.inst] !== e.data) begin
        bad++;
        $display("FAIL sweep_result[%0d]: got %h want %h", e.inst, ct_obs[e.inst], e.data);
      end
    end
  endtask

  task automatic test_run_held;
    exp_t e;
    int   rises;
    int   rise_k;
    logic prev;
    logic hold_ok;
    rises   = 0;
    rise_k  = -1;
    prev    = rdy[0];
    hold_ok = 1'b1;
    sb.push_back('{inst: 0, data: Ct1, lat: 12});
    @(negedge Clk);
    Run = 1'b1;
    @(negedge Clk);
    for (int k = 0; k < 30; k++) begin
      if (k == 3) pt = '1;
      if (rdy[0] === 1'b1 && prev !== 1'b1) begin
        rises++;
        if (rise_k < 0) rise_k = k;
      end
      prev = rdy[0];
      if (k >= 12 && (rdy[0] !== 1'b1 || ct_o[0] !== Ct1 || bsy[0] !== 1'b0)) hold_ok = 1'b0;
      @(negedge Clk);
    end
    e = sb.pop_front();
    total++;
    if (rise_k !== e.lat) begin
      bad++;
      $display("FAIL held_latency: got %0d want %0d", rise_k, e.lat);
    end
    total++;
    if (rises !== 1) begin
      bad++;
      $display("FAIL held_one_op: got %0d ready rises want 1", rises);
    end
    total++;
    if (hold_ok !== 1'b1) begin
      bad++;
      $display("FAIL held_stable: got %b want 1", hold_ok);
    end
    for (int i = 2; i < 5; i++) begin
      total++;
      if (ct_o[i] !== Ct1) begin
        bad++;
        $display("FAIL held_result[%0d]: got %h want %h", i, ct_o[i], Ct1);
      end
    end
    Run = 1'b0;
    @(negedge Clk);
    total++;
    if (rdy[0] !== 1'b0) begin
      bad++;
      $display("FAIL held_release_ready: got %b want 0", rdy[0]);
    end
    total++;
    if (ct_o[0] !== Ct1) begin
      bad++;
      $display("FAIL held_release_ct: got %h want %h", ct_o[0], Ct1);
    end
    pt = Pt1;
  endtask

  task automatic test_reset_mid;
    exp_t e;
    pulse_run();
    repeat (4) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    total++;
    if (rdy[0] !== 1'b0 || bsy[0] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_flags: got ready=%b busy=%b want 0 0", rdy[0], bsy[0]);
    end
    total++;
    if (ct_o[0] !== 128'h0) begin
      bad++;
      $display("FAIL mid_reset_ct: got %h want 0", ct_o[0]);
    end
    @(negedge Clk);
    sb.push_back('{inst: 0, data: Ct1, lat: 12});
    pulse_run();
    measure(16);
    e = sb.pop_front();
    total++;
    if (lat_obs[0] !== e.lat || ct_obs[0] !== e.data) begin
      bad++;
      $display("FAIL mid_reset_rerun: got lat=%0d ct=%h want lat=%0d ct=%h",
               lat_obs[0], ct_obs[0], e.lat, e.data);
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    int   rise_k;
    logic held_ok;
    sb.push_back('{inst: 0, data: Ct1, lat: 12});
    sb.push_back('{inst: 1, data: Pt1, lat: 12});
    pulse_run();
    measure(16);
    for (int n = 0; n < 2; n++) begin
      e = sb.pop_front();
      total++;
      if (lat_obs[e.inst] !== e.lat || ct_obs[e.inst] !== e.data) begin
        bad++;
        $display("FAIL b2b_first[%0d]: got lat=%0d ct=%h want lat=%0d ct=%h",
                 e.inst, lat_obs[e.inst], ct_obs[e.inst], e.lat, e.data);
      end
    end
    key    = Key2;
    pt     = Pt2;
    pt_dec = Ct2;
    sb.push_back('{inst: 0, data: Ct2, lat: 12});
    sb.push_back('{inst: 1, data: Pt2, lat: 12});
    pulse_run();
    for (int i = 0; i < 5; i++) lat_obs[i] = -1;
    rise_k  = -1;
    held_ok = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (lat_obs[i] < 0 && rdy[i] === 1'b1) begin
          lat_obs[i] = k;
          ct_obs[i]  = ct_o[i];
        end
      end
      if (lat_obs[0] < 0 && ct_o[0] !== Ct1) held_ok = 1'b0;
      @(negedge Clk);
    end
    total++;
    if (held_ok !== 1'b1) begin
      bad++;
      $display("FAIL b2b_hold_first: got %b want 1", held_ok);
    end
    for (int n = 0; n < 2; n++) begin
      e = sb.pop_front();
      total++;
      if (lat_obs[e.inst] !== e.lat || ct_obs[e.inst] !== e.data) begin
        bad++;
        $display("FAIL b2b_second[%0d]: got lat=%0d ct=%h want lat=%0d ct=%h",
                 e.inst, lat_obs[e.inst], ct_obs[e.inst], e.lat, e.data);
      end
    end
    // Reset and Run on the same edge: reset wins, nothing starts.
    Reset = 1'b1;
    Run   = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    Run   = 1'b0;
    total++;
    if (bsy !== 5'b0 || rdy !== 5'b0) begin
      bad++;
      $display("FAIL reset_run_same_edge: got busy=%b ready=%b want 00000 00000", bsy, rdy);
    end
    total++;
    if (ct_o[0] !== 128'h0) begin
      bad++;
      $display("FAIL reset_run_ct: got %h want 0", ct_o[0]);
    end
    held_ok = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      if (bsy !== 5'b0) held_ok = 1'b0;
    end
    total++;
    if (held_ok !== 1'b1) begin
      bad++;
      $display("FAIL reset_run_no_start: got %b want 1", held_ok);
    end
  endtask

  initial begin
    test_reset();
    test_latency_sweep();
    test_run_held();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
